// File: rtl/axil_protocol_monitor.sv
// axil_protocol_monitor: passive AXI-Lite checker with sticky error flags, first-error capture and done counters
module axil_protocol_monitor #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 256,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] axil_awaddr,
  input  logic [2:0]            axil_awprot,
  input  logic                  axil_awvalid,
  input  logic                  axil_awready,
  input  logic [DATA_WIDTH-1:0] axil_wdata,
  input  logic [STRB_WIDTH-1:0] axil_wstrb,
  input  logic                  axil_wvalid,
  input  logic                  axil_wready,
  input  logic [1:0]            axil_bresp,
  input  logic                  axil_bvalid,
  input  logic                  axil_bready,
  input  logic [ADDR_WIDTH-1:0] axil_araddr,
  input  logic [2:0]            axil_arprot,
  input  logic                  axil_arvalid,
  input  logic                  axil_arready,
  input  logic [DATA_WIDTH-1:0] axil_rdata,
  input  logic [1:0]            axil_rresp,
  input  logic                  axil_rvalid,
  input  logic                  axil_rready,
  input  logic                  clr_err,
  output logic [11:0]           err_flags,
  output logic [3:0]            first_err_idx,
  output logic                  first_err_vld,
  output logic                  err_irq,
  output logic [CNT_WIDTH-1:0]  wr_done_cnt,
  output logic [CNT_WIDTH-1:0]  rd_done_cnt
);
  localparam int PA = ADDR_WIDTH + 3;
  localparam int PD = DATA_WIDTH + STRB_WIDTH;
  localparam int PR = DATA_WIDTH + 2;
  localparam int PW = (PA > PD) ? ((PA > PR) ? PA : PR) : ((PD > PR) ? PD : PR);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TEN = TIMEOUT != 0;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);
  localparam logic [TW-1:0] TM1 = TW'(TIMEOUT - 1);
  localparam logic [7:0] MAXO = 8'(MAX_OUTSTANDING);
  logic [4:0]           w_vld, w_rdy, w_hs, w_stl, w_unst, w_sreach;
  logic [PW-1:0]        w_pl [5];
  logic [PW-1:0]        r_pl [5];
  logic [4:0]           r_stl;
  logic [TW-1:0]        r_sc [5];
  logic [TW-1:0]        w_sc [5];
  logic [TW-1:0]        r_wt, r_rt, w_wt, w_rt;
  logic [7:0]           r_aw, r_w, r_ar;
  logic [8:0]           w_aw, w_w, w_ar;
  logic [11:0]          w_new, r_flags;
  logic [3:0]           w_idx, r_idx;
  logic                 r_fvld, r_irq;
  logic [CNT_WIDTH-1:0] r_wc, r_rc;
  // channel order: 0 AW, 1 W, 2 AR, 3 B, 4 R (matches error bits 0-4)
  assign w_vld = {axil_rvalid, axil_bvalid, axil_arvalid, axil_wvalid, axil_awvalid};
  assign w_rdy = {axil_rready, axil_bready, axil_arready, axil_wready, axil_awready};
  assign w_hs  = w_vld & w_rdy;
  assign w_stl = w_vld & ~w_rdy;
  assign w_pl[0] = PW'({axil_awprot, axil_awaddr});
  assign w_pl[1] = PW'({axil_wstrb, axil_wdata});
  assign w_pl[2] = PW'({axil_arprot, axil_araddr});
  assign w_pl[3] = PW'(axil_bresp);
  assign w_pl[4] = PW'({axil_rresp, axil_rdata});
  // {overflow, next}: an increment past the limit flags and holds
  function automatic logic [8:0] pend(input logic [7:0] p, input logic inc, input logic dec);
    return (inc && !dec && p >= MAXO) ? {1'b1, p} : {1'b0, p + 8'(inc) - 8'(dec)};
  endfunction
  function automatic logic [TW-1:0] tinc(input logic [TW-1:0] c);
    return (c == TLIM) ? c : c + TW'(1);
  endfunction
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_unst[i]   = r_stl[i] & (~w_vld[i] | (w_pl[i] != r_pl[i]));
      w_sreach[i] = TEN & w_stl[i] & (r_sc[i] == TM1);
      w_sc[i]     = (TEN && w_stl[i]) ? tinc(r_sc[i]) : '0;
    end
    w_aw = pend(r_aw, w_hs[0], w_hs[3] && r_aw != 0);
    w_w  = pend(r_w,  w_hs[1], w_hs[3] && r_w != 0);
    w_ar = pend(r_ar, w_hs[2], w_hs[4] && r_ar != 0);
    w_wt = (TEN && r_aw != 0 && !w_hs[3]) ? tinc(r_wt) : '0;
    w_rt = (TEN && r_ar != 0 && !w_hs[4]) ? tinc(r_rt) : '0;
    w_new = {TEN && r_ar != 0 && !w_hs[4] && r_rt == TM1,
             TEN && r_aw != 0 && !w_hs[3] && r_wt == TM1,
             |w_sreach, w_ar[8], w_aw[8] | w_w[8],
             w_hs[4] && r_ar == 0,
             w_hs[3] && (r_aw == 0 || r_w == 0),
             w_unst};
    w_idx = '0;
    for (int i = 11; i >= 0; i--) if (w_new[i]) w_idx = 4'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stl   <= '0;
      r_aw    <= '0;
      r_w     <= '0;
      r_ar    <= '0;
      r_wt    <= '0;
      r_rt    <= '0;
      r_flags <= '0;
      r_idx   <= '0;
      r_fvld  <= 1'b0;
      r_irq   <= 1'b0;
      r_wc    <= '0;
      r_rc    <= '0;
      for (int i = 0; i < 5; i++) begin
        r_pl[i] <= '0;
        r_sc[i] <= '0;
      end
    end else begin
      r_stl <= w_stl;
      for (int i = 0; i < 5; i++) begin
        r_pl[i] <= w_pl[i];
        r_sc[i] <= w_sc[i];
      end
      r_aw    <= w_aw[7:0];
      r_w     <= w_w[7:0];
      r_ar    <= w_ar[7:0];
      r_wt    <= w_wt;
      r_rt    <= w_rt;
      r_flags <= (clr_err ? '0 : r_flags) | w_new;
      r_irq   <= |r_flags & ~clr_err;
      if (w_new != 0 && (clr_err || !r_fvld)) begin
        r_idx  <= w_idx;
        r_fvld <= 1'b1;
      end else if (clr_err) begin
        r_idx  <= '0;
        r_fvld <= 1'b0;
      end
      r_wc <= r_wc + CNT_WIDTH'(w_hs[3] && !(&r_wc));
      r_rc <= r_rc + CNT_WIDTH'(w_hs[4] && !(&r_rc));
    end
  end
  assign err_flags     = r_flags;
  assign first_err_idx = r_idx;
  assign first_err_vld = r_fvld;
  assign err_irq       = r_irq;
  assign wr_done_cnt   = r_wc;
  assign rd_done_cnt   = r_rc;
endmodule
